// File: rtl/chip_pkg.sv
// Chip codes and output-pin masks shared by the 74xx emulator.
package chip_pkg;

   localparam int CHIP_PIN_W = 17;

   typedef enum logic [4:0] {
      C7400 = 5'd1,
      C7402 = 5'd2,
      C7404 = 5'd3,
      C7410 = 5'd4,
      C7420 = 5'd5,
      C7427 = 5'd6,
      C7474 = 5'd7,
      C7486 = 5'd9
   } chip_code_e;

   // Pins the selected chip drives; zero for any unsupported code.
   function automatic logic [CHIP_PIN_W-1:0] out_mask(chip_code_e code);
      case (code)
         C7400, C7486: out_mask = 17'h00948;
         C7402:        out_mask = 17'h02412;
         C7404:        out_mask = 17'h01554;
         C7410, C7427: out_mask = 17'h01140;
         C7420:        out_mask = 17'h00140;
         C7474:        out_mask = 17'h00360;
         default:      out_mask = '0;
      endcase
   endfunction

endpackage

// File: rtl/chip_emulator_pin_sync.sv
// Multi-stage synchronizer for the sampled header pins.
module pin_sync
   import chip_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CHIP_PIN_W-1:0] d,
   output logic [CHIP_PIN_W-1:0] q
);

   logic [CHIP_PIN_W-1:0] chain [STAGES];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/chip_emulator.sv
// Known-good 74xx model on the checker's 16-pin header: sync pins, evaluate
// the selected chip, drive only its outputs, with optional stuck-at fault.
module chip_emulator
   import chip_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [4:0]  Chip_Sel,
   input  logic [16:0] Pin_In,
   output logic [16:0] Pin_Out,
   output logic [16:0] Pin_OE,
   input  logic        Fault_En,
   input  logic [4:0]  Fault_Pin,
   input  logic        Fault_Val,
   output logic        Sel_Err
);

   logic [16:0] p, mask, func, out_nx;
   chip_code_e  sel_code;
   logic [4:0]  sel_shadow;
   logic [3:0]  settle_cnt;
   logic        q1, q2, q1_nx, q2_nx, qn1, qn2, clk1_d, clk2_d;
   logic        unused_pins;

   pin_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (Clk),
      .reset (Reset),
      .d     (Pin_In),
      .q     (p)
   );

   assign sel_code    = chip_code_e'(Chip_Sel);
   assign mask        = out_mask(sel_code);
   assign unused_pins = ^{p[16:14], p[7], p[0]};

   // 7474 next state: PRE/CLR are level-sensitive and show up with gate latency.
   always_comb begin
      q1_nx = q1;
      if (!p[4])                q1_nx = 1'b1;
      else if (!p[1])           q1_nx = 1'b0;
      else if (p[3] && !clk1_d) q1_nx = p[2];
      qn1 = (!p[4] && !p[1]) ? 1'b1 : ~q1_nx;

      q2_nx = q2;
      if (!p[10])                q2_nx = 1'b1;
      else if (!p[13])           q2_nx = 1'b0;
      else if (p[11] && !clk2_d) q2_nx = p[12];
      qn2 = (!p[10] && !p[13]) ? 1'b1 : ~q2_nx;
   end

   always_comb begin
      func = '0;
      case (sel_code)
         C7400: begin
            func[3]  = ~(p[1] & p[2]);
            func[6]  = ~(p[4] & p[5]);
            func[8]  = ~(p[9] & p[10]);
            func[11] = ~(p[12] & p[13]);
         end
         C7486: begin
            func[3]  = p[1] ^ p[2];
            func[6]  = p[4] ^ p[5];
            func[8]  = p[9] ^ p[10];
            func[11] = p[12] ^ p[13];
         end
         C7402: begin
            func[1]  = ~(p[2] | p[3]);
            func[4]  = ~(p[5] | p[6]);
            func[10] = ~(p[8] | p[9]);
            func[13] = ~(p[11] | p[12]);
         end
         C7404: begin
            func[2]  = ~p[1];
            func[4]  = ~p[3];
            func[6]  = ~p[5];
            func[8]  = ~p[9];
            func[10] = ~p[11];
            func[12] = ~p[13];
         end
         C7410: begin
            func[12] = ~(p[1] & p[2] & p[13]);
            func[6]  = ~(p[3] & p[4] & p[5]);
            func[8]  = ~(p[9] & p[10] & p[11]);
         end
         C7427: begin
            func[12] = ~(p[1] | p[2] | p[13]);
            func[6]  = ~(p[3] | p[4] | p[5]);
            func[8]  = ~(p[9] | p[10] | p[11]);
         end
         C7420: begin
            func[6]  = ~(p[1] & p[2] & p[4] & p[5]);
            func[8]  = ~(p[9] & p[10] & p[12] & p[13]);
         end
         C7474: begin
            func[5]  = q1_nx;
            func[6]  = qn1;
            func[9]  = q2_nx;
            func[8]  = qn2;
         end
         default: func = '0;
      endcase
   end

   always_comb begin
      out_nx = func & mask;
      if (Fault_En && (Fault_Pin < 5'd17) && mask[Fault_Pin]) out_nx[Fault_Pin] = Fault_Val;
   end

   // Outputs stay released until the settle down-counter expires.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         Pin_Out    <= '0;
         Pin_OE     <= '0;
         Sel_Err    <= 1'b0;
         q1         <= 1'b0;
         q2         <= 1'b0;
         clk1_d     <= 1'b0;
         clk2_d     <= 1'b0;
         sel_shadow <= '0;
         settle_cnt <= 4'(SETTLE_CYCLES);
      end else begin
         Sel_Err <= (mask == '0);
         clk1_d  <= p[3];
         clk2_d  <= p[11];
         if (Chip_Sel != sel_shadow) begin
            sel_shadow <= Chip_Sel;
            settle_cnt <= 4'(SETTLE_CYCLES);
            q1         <= 1'b0;
            q2         <= 1'b0;
            Pin_OE     <= '0;
            Pin_Out    <= '0;
         end else begin
            q1 <= q1_nx;
            q2 <= q2_nx;
            if (settle_cnt > 4'd1) begin
               settle_cnt <= settle_cnt - 4'd1;
               Pin_OE     <= '0;
               Pin_Out    <= '0;
            end else begin
               settle_cnt <= 4'd0;
               Pin_OE     <= mask;
               Pin_Out    <= out_nx;
            end
         end
      end
   end

endmodule

// File: tb/tb_chip_emulator.sv
// Self-checking bench for chip_emulator: pin-table reference model plus directed vectors.
module tb_chip_emulator;

   localparam int SETTLE = 4;

   logic        Clk = 1'b0;
   logic        Reset, Fault_En, Fault_Val, Sel_Err;
   logic [4:0]  Chip_Sel, Fault_Pin;
   logic [16:0] Pin_In, Pin_Out, Pin_OE;

   int checks = 0;
   int errors = 0;

   chip_emulator #(.SYNC_STAGES(2), .SETTLE_CYCLES(SETTLE)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Chip_Sel  (Chip_Sel),
      .Pin_In    (Pin_In),
      .Pin_Out   (Pin_Out),
      .Pin_OE    (Pin_OE),
      .Fault_En  (Fault_En),
      .Fault_Pin (Fault_Pin),
      .Fault_Val (Fault_Val),
      .Sel_Err   (Sel_Err)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Output pins of each chip, from its data-sheet pinout.
   function automatic logic [16:0] mask_of(input logic [4:0] code);
      case (code)
         5'd1, 5'd9: return 17'h00948;
         5'd2:       return 17'h02412;
         5'd3:       return 17'h01554;
         5'd4, 5'd6: return 17'h01140;
         5'd5:       return 17'h00140;
         5'd7:       return 17'h00360;
         default:    return 17'h0;
      endcase
   endfunction

   // Gate chips described as (output pin, input pins) tables.
   function automatic logic [16:0] gates_of(input logic [4:0] code, input logic [16:0] s);
      logic [16:0] y;
      y = '0;
      case (code)
         5'd1, 5'd9: begin
            int o[4] = '{3, 6, 8, 11};
            int a[4] = '{1, 4, 9, 12};
            int b[4] = '{2, 5, 10, 13};
            for (int i = 0; i < 4; i++)
               y[o[i]] = (code == 5'd1) ? !(s[a[i]] && s[b[i]]) : (s[a[i]] != s[b[i]]);
         end
         5'd2: begin
            int o[4] = '{1, 4, 10, 13};
            int a[4] = '{2, 5, 8, 11};
            int b[4] = '{3, 6, 9, 12};
            for (int i = 0; i < 4; i++) y[o[i]] = !(s[a[i]] || s[b[i]]);
         end
         5'd3: begin
            int o[6] = '{2, 4, 6, 8, 10, 12};
            int a[6] = '{1, 3, 5, 9, 11, 13};
            for (int i = 0; i < 6; i++) y[o[i]] = !s[a[i]];
         end
         5'd4, 5'd6: begin
            int o[3] = '{12, 6, 8};
            int a[3] = '{1, 3, 9};
            int b[3] = '{2, 4, 10};
            int c[3] = '{13, 5, 11};
            for (int i = 0; i < 3; i++) begin
               int ones;
               ones = int'(s[a[i]]) + int'(s[b[i]]) + int'(s[c[i]]);
               y[o[i]] = (code == 5'd4) ? (ones != 3) : (ones == 0);
            end
         end
         5'd5: begin
            y[6] = !(s[1] && s[2] && s[4] && s[5]);
            y[8] = !(s[9] && s[10] && s[12] && s[13]);
         end
         default: y = '0;
      endcase
      return y;
   endfunction

   // Reference model state, advanced on every rising edge.
   logic        m_valid = 1'b0;
   logic [4:0]  m_sel;
   int          m_left;
   logic [16:0] m_h0, m_h1, ms, my, exp_out, exp_oe;
   logic        m_q1, m_q2, m_c1, m_c2, rise1, rise2, exp_err;

   always @(posedge Clk) begin
      if (Reset) begin
         m_valid = 1'b1;
         m_sel = '0; m_left = SETTLE;
         m_h0 = '0; m_h1 = '0;
         m_q1 = 1'b0; m_q2 = 1'b0; m_c1 = 1'b0; m_c2 = 1'b0;
         exp_out = '0; exp_oe = '0; exp_err = 1'b0;
      end else if (m_valid) begin
         ms = m_h1;
         exp_err = (mask_of(Chip_Sel) == 17'h0);
         rise1 = ms[3] && !m_c1;
         rise2 = ms[11] && !m_c2;
         m_c1 = ms[3];
         m_c2 = ms[11];
         if (Chip_Sel != m_sel) begin
            m_sel = Chip_Sel; m_left = SETTLE;
            m_q1 = 1'b0; m_q2 = 1'b0;
            exp_oe = '0; exp_out = '0;
         end else begin
            if (!ms[4]) m_q1 = 1'b1; else if (!ms[1]) m_q1 = 1'b0; else if (rise1) m_q1 = ms[2];
            if (!ms[10]) m_q2 = 1'b1; else if (!ms[13]) m_q2 = 1'b0; else if (rise2) m_q2 = ms[12];
            if (m_left > 1) begin
               m_left--;
               exp_oe = '0; exp_out = '0;
            end else begin
               m_left = 0;
               if (m_sel == 5'd7) begin
                  my = '0;
                  my[5] = m_q1;
                  my[6] = (!ms[4] && !ms[1]) ? 1'b1 : !m_q1;
                  my[9] = m_q2;
                  my[8] = (!ms[10] && !ms[13]) ? 1'b1 : !m_q2;
               end else begin
                  my = gates_of(m_sel, ms);
               end
               if (Fault_En && Fault_Pin <= 5'd16 && mask_of(m_sel)[Fault_Pin]) my[Fault_Pin] = Fault_Val;
               exp_oe = mask_of(m_sel);
               exp_out = my & exp_oe;
            end
         end
         m_h1 = m_h0;
         m_h0 = Pin_In;
      end
   end

   always @(negedge Clk) begin
      if (m_valid) begin
         check("model_pin_out", Pin_Out, exp_out);
         check("model_pin_oe", Pin_OE, exp_oe);
         check("model_sel_err", {16'b0, Sel_Err}, {16'b0, exp_err});
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge Clk);
   endtask

   logic [16:0] pats [5] = '{17'h00000, 17'h1FFFE, 17'h0AAAA, 17'h15554, 17'h0F0F0};
   logic [4:0]  codes [8] = '{5'd4, 5'd5, 5'd6, 5'd9, 5'd2, 5'd3, 5'd7, 5'd1};

   initial begin
      Reset = 1'b1; Chip_Sel = 5'd0; Pin_In = '0;
      Fault_En = 1'b0; Fault_Pin = 5'd0; Fault_Val = 1'b0;
      tick(2);
      check("reset_oe", Pin_OE, 17'h0);
      check("reset_out", Pin_Out, 17'h0);
      check("reset_err", {16'b0, Sel_Err}, 17'h0);

      // 7400 truth table and latency
      Reset = 1'b0; Chip_Sel = 5'd1;
      tick(6);
      check("nand_oe", Pin_OE, 17'h00948);
      check("nand_all_low", Pin_Out, 17'h00948);
      Pin_In = 17'h00006;
      tick(2);
      check("nand_lat2", {16'b0, Pin_Out[3]}, 17'h1);
      tick(1);
      check("nand_11", {16'b0, Pin_Out[3]}, 17'h0);
      check("pin0_low", {16'b0, Pin_Out[0]}, 17'h0);
      Pin_In = 17'h00004;
      tick(3);
      check("nand_01", {16'b0, Pin_Out[3]}, 17'h1);

      // select change and re-change during settling
      Chip_Sel = 5'd3;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         check("settle_oe0", Pin_OE, 17'h0);
      end
      tick(1);
      check("inv_oe", Pin_OE, 17'h01554);
      Chip_Sel = 5'd1;
      tick(2);
      Chip_Sel = 5'd3;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         check("resettle_oe0", Pin_OE, 17'h0);
      end
      tick(1);
      check("resettle_oe", Pin_OE, 17'h01554);

      // 7474 edge capture, hold, and preset+clear
      Pin_In = 17'h02416;
      tick(3);
      Chip_Sel = 5'd7;
      tick(6);
      check("ff_oe", Pin_OE, 17'h00360);
      check("ff_q0", Pin_Out, 17'h00140);
      Pin_In = 17'h0241E;
      tick(3);
      check("ff_capture", Pin_Out, 17'h00120);
      Pin_In = 17'h0241A;
      tick(4);
      check("ff_hold", Pin_Out, 17'h00120);
      Pin_In = 17'h02408;
      tick(3);
      check("ff_pre_clr", Pin_Out, 17'h00160);
      Pin_In = 17'h0241A;
      tick(3);
      check("ff_q1_kept", Pin_Out, 17'h00120);

      // reset mid-operation
      Reset = 1'b1;
      tick(1);
      check("midrst_oe", Pin_OE, 17'h0);
      check("midrst_out", Pin_Out, 17'h0);
      Reset = 1'b0;
      tick(3);
      check("midrst_settle", Pin_OE, 17'h0);
      tick(3);
      check("midrst_oe_back", Pin_OE, 17'h00360);
      check("midrst_q1", {15'b0, Pin_Out[6:5]}, 17'h2);

      // unsupported code, then 7486
      Chip_Sel = 5'd8;
      tick(1);
      check("unsup_err", {16'b0, Sel_Err}, 17'h1);
      check("unsup_oe", Pin_OE, 17'h0);
      tick(6);
      check("unsup_out", Pin_Out, 17'h0);
      check("unsup_oe_hold", Pin_OE, 17'h0);
      Chip_Sel = 5'd9; Pin_In = 17'h00032;
      tick(1);
      check("xor_err", {16'b0, Sel_Err}, 17'h0);
      tick(5);
      check("xor_oe", Pin_OE, 17'h00948);
      check("xor_out", Pin_Out, 17'h00008);

      // fault injection
      Chip_Sel = 5'd2; Pin_In = 17'h0;
      tick(6);
      check("nor_out", Pin_Out, 17'h02412);
      Fault_En = 1'b1; Fault_Pin = 5'd1; Fault_Val = 1'b0;
      tick(1);
      check("fault_out", Pin_Out, 17'h02410);
      Fault_Pin = 5'd2;
      tick(1);
      check("fault_in_pin", Pin_Out, 17'h02412);
      check("fault_in_oe", Pin_OE, 17'h02412);
      Fault_Pin = 5'd4; Chip_Sel = 5'd3;
      tick(1);
      check("fault_settle_oe", Pin_OE, 17'h0);
      check("fault_settle_out", Pin_Out, 17'h0);
      tick(5);
      check("fault_inv", Pin_Out, 17'h01544);
      Fault_En = 1'b0;

      // pattern sweep across all chips
      foreach (codes[c]) begin
         Chip_Sel = codes[c];
         tick(6);
         foreach (pats[k]) begin
            Pin_In = pats[k];
            tick(3);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/chip_emulator.md
Name: chip_emulator

Overview:
- FPGA-side model of a known-good 74xx DIP that responds on the same 16-pin header the chip checker drives.
- Samples the pins the checker drives, computes the selected chip's function, and drives only that chip's output pins.
- Lets the checker be verified end-to-end without a physical chip, using loopback through the header.
- Optional fault injection forces one output pin to a fixed value, to prove the checker reports a bad chip.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on each sampled pin, valid range 2..3.
- SETTLE_CYCLES, 4: cycles Pin_OE stays all-zero after reset or after a Chip_Sel change, range 1..15.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- Chip_Sel  in  5  chip code, using the same selection codes as the checker: 1=7400, 2=7402, 3=7404, 4=7410, 5=7420, 6=7427, 7=7474, 9=7486; all other codes unsupported
- Pin_In  in  17  sampled header pins, bit n = pin n; bit 0 unused
- Pin_Out  out  17  value driven on each pin; bit 0 is always 0
- Pin_OE  out  17  1 = the emulator drives that pin; the top level tri-states the pin when 0
- Fault_En  in  1  enable stuck-at fault injection
- Fault_Pin  in  5  pin number the fault is forced on
- Fault_Val  in  1  value the faulted pin is stuck at
- Sel_Err  out  1  registered; 1 when Chip_Sel is unsupported

Behaviour:
- Reset values: Pin_Out=0, Pin_OE=0, Sel_Err=0, all sync flops=0, 7474 Q1=Q2=0, settle counter=SETTLE_CYCLES, Chip_Sel shadow register=0.
- Pin_In passes through SYNC_STAGES flops before use.
- Pin_Out is registered. A change on Pin_In becomes visible on Pin_Out at rising edge SYNC_STAGES+1 after the change (3 with the defaults).
- Output-pin masks (Pin_OE=1 only on these; Pin_Out=0 on every non-output pin):
  - 7400 and 7486: pins 3, 6, 8, 11
  - 7402: pins 1, 4, 10, 13
  - 7404: pins 2, 4, 6, 8, 10, 12
  - 7410 and 7427: pins 6, 8, 12
  - 7420: pins 6, 8
  - 7474: pins 5, 6, 8, 9
- Pin functions:
  - 7400 NAND / 7486 XOR: Y3=f(1,2), Y6=f(4,5), Y8=f(9,10), Y11=f(12,13).
  - 7402 NOR: Y1=f(2,3), Y4=f(5,6), Y10=f(8,9), Y13=f(11,12).
  - 7404 inverter: Y2=~1, Y4=~3, Y6=~5, Y8=~9, Y10=~11, Y12=~13.
  - 7410 3-input NAND / 7427 3-input NOR: Y12=f(1,2,13), Y6=f(3,4,5), Y8=f(9,10,11).
  - 7420 4-input NAND: Y6=f(1,2,4,5), Y8=f(9,10,12,13). Pins 3 and 11 are NC.
  - 7474 flop 1: CLR=1, D=2, CLK=3, PRE=4, Q=5, Qn=6.
  - 7474 flop 2: Qn=8, Q=9, PRE=10, CLK=11, D=12, CLR=13.
- 7474 rules (per flop, in priority order):
  - PRE=0 and CLR=0: Q=1 and Qn=1.
  - Else PRE=0: Q=1.
  - Else CLR=0: Q=0.
  - Else a rising edge on the synchronized CLK (last sync stage 0 to 1, compared with a one-cycle-delayed copy) captures the synchronized D.
  - PRE and CLR are level-sensitive on synchronized values and act in the same cycle they are seen, with the same latency as gate outputs.
  - Qn=~Q except in the both-low case.
- Chip_Sel change (compared against the shadow register):
  - Same cycle: Pin_OE forced to 0, settle counter reloaded with SETTLE_CYCLES, 7474 state cleared to Q=0.
  - Pin_OE returns to the new chip's mask once the counter reaches 0.
  - A further change during settling reloads the counter.
- Unsupported Chip_Sel: Sel_Err=1 from the next edge, Pin_OE=0 and Pin_Out=0 for as long as the code is selected.
- Fault injection:
  - Applies only when Fault_En=1 and Fault_Pin is in the current output mask.
  - The faulted Pin_Out bit equals Fault_Val at the output register, and takes effect on the next edge.
  - Fault_En=1 with a non-output pin: no effect.
  - The fault never overrides Pin_OE=0 during settling.
- Reset asserted mid-operation: all state returns to its reset values on that edge; the settle window restarts.

Decomposition:
- Shared package chip_pkg:
  - chip_code_e enum (C7400=1 .. C7486=9)
  - function out_mask(chip_code_e) returning logic [16:0]
  - CHIP_PIN_W=17
- One sub-module, pin_sync: a SYNC_STAGES-deep flop chain on the 17-bit vector, with the same reset.
- Gate evaluation is a combinational case on Chip_Sel inside chip_emulator.
- The two 7474 flops are inlined.

Test Plan:
- 7400 truth table: Chip_Sel=1, wait SETTLE_CYCLES; drive pins 1,2=11 then 01 → Pin_Out[3]=0, then 1, each 3 edges after the input change; Pin_OE=0x0948 (pins 3,6,8,11); Pin_Out bit 0=0.
- 7474 edge capture: Chip_Sel=7, PRE=CLR=1, D(pin2)=1, pin3 goes 0→1 → Q(pin5)=1, Qn(pin6)=0 after 3 edges. D=0 with pin3 held high → no change. PRE=0 and CLR=0 → pins 5 and 6 both 1.
- Select change: switch Chip_Sel 1→3 mid-stream → Pin_OE=0 for 4 cycles, then 0x1554 (pins 2,4,6,8,10,12). A second change at the 2nd settle cycle → 4 more zero-OE cycles.
- Unsupported code: Chip_Sel=8 → Sel_Err=1, Pin_OE=0, Pin_Out=0. Then Chip_Sel=9 → Sel_Err=0 and XOR outputs after settling.
- Fault injection: Chip_Sel=2, pins 2,3=00 gives Y1=1. Fault_En=1, Fault_Pin=1, Fault_Val=0 → Pin_Out[1]=0. Fault_Pin=2 (an input pin) → Pin_Out unchanged, Pin_OE unchanged.
- Reset mid-operation: assert Reset for 1 cycle during 7474 Q=1 → next edge Pin_OE=0, Q state=0, settle window restarts.
